// File: rtl/dmem_store_buffer_if.sv
// dmem_store_buffer_if: core-side load/store signals and memory-side write/read bus of the store buffer
interface dmem_store_buffer_if #(
  parameter int AW = 32
);
  logic          memwrite;
  logic [AW-1:0] aluout;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          stall;
  logic          sb_empty;
  logic          mem_wreq;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          mem_wack;
  logic [AW-1:0] mem_raddr;
  logic [31:0]   mem_rdata;
  modport slave (
    input  memwrite, aluout, writedata, mem_wack, mem_rdata,
    output readdata, stall, sb_empty, mem_wreq, mem_waddr, mem_wdata, mem_raddr
  );
  modport master (
    output memwrite, aluout, writedata, mem_wack, mem_rdata,
    input  readdata, stall, sb_empty, mem_wreq, mem_waddr, mem_wdata, mem_raddr
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-store FIFO draining to data memory, with store-to-load forwarding
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input logic            clk,
  input logic            reset,
  dmem_store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;
  logic             full, empty, push, pop;
  logic [AW-1:0]    word_addr;
  assign word_addr     = {bus.aluout[AW-1:2], 2'b00};
  assign full          = count == CW'(DEPTH);
  assign empty         = count == '0;
  assign push          = bus.memwrite && !full;
  assign pop           = !empty && bus.mem_wack;
  assign bus.stall     = full;
  assign bus.sb_empty  = empty;
  assign bus.mem_wreq  = !empty;
  assign bus.mem_waddr = empty ? '0 : addr_q[head];
  assign bus.mem_wdata = empty ? '0 : data_q[head];
  assign bus.mem_raddr = word_addr;
  // Walk oldest to youngest so the last match (the youngest store) wins
  always_comb begin
    bus.readdata = bus.mem_rdata;
    for (int k = 0; k < DEPTH; k++)
      if (valid_q[head + PW'(k)] && addr_q[head + PW'(k)] == word_addr)
        bus.readdata = data_q[head + PW'(k)];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      if (push) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // Entry payload needs no reset: it is only observed through valid_q or a non-empty head
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= word_addr;
      data_q[tail] <= bus.writedata;
    end
  end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: directed scoreboard bench for the store buffer
module tb_dmem_store_buffer;
  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail = 0;
  logic [63:0] sbq[$];
  always #5 clk = ~clk;
  dmem_store_buffer_if #(.AW(32)) bus ();
  dmem_store_buffer #(.DEPTH(4), .AW(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every accepted memory write must match the oldest store still expected
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.mem_wreq === 1'b1 && bus.mem_wack === 1'b1) begin
      chk("write_expected", {31'b0, sbq.size() != 0}, 32'd1);
      if (sbq.size() != 0) begin
        chk("wr_addr", bus.mem_waddr, sbq[0][63:32]);
        chk("wr_data", bus.mem_wdata, sbq[0][31:0]);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite  = 1'b1;
    bus.aluout    = a;
    bus.writedata = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.stall === 1'b0) break;
    end
    chk("store_accept", {31'b0, bus.stall}, 32'd0);
    sbq.push_back({a & ~32'h3, d});
    @(posedge clk); #1;
    bus.memwrite = 1'b0;
  endtask

  task automatic drain();
    bus.mem_wack = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.sb_empty === 1'b1) break;
    end
    chk("drain_empty", {31'b0, bus.sb_empty}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.memwrite  = 1'b0;
    bus.aluout    = 32'h41;
    bus.writedata = '0;
    bus.mem_wack  = 1'b0;
    bus.mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rst_wreq", {31'b0, bus.mem_wreq}, 32'd0);
    chk("rst_empty", {31'b0, bus.sb_empty}, 32'd1);
    chk("rst_stall", {31'b0, bus.stall}, 32'd0);
    chk("rst_waddr", bus.mem_waddr, 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_readdata", bus.readdata, 32'hDEADBEEF);
    chk("rst_raddr", bus.mem_raddr, 32'h40);
    @(posedge clk); #1;
    reset = 1'b0;
    // single store, memory always ready
    bus.mem_wack  = 1'b1;
    bus.memwrite  = 1'b1;
    bus.aluout    = 32'h100;
    bus.writedata = 32'h11111111;
    @(negedge clk);
    chk("lat_wreq_before_accept", {31'b0, bus.mem_wreq}, 32'd0);
    chk("single_stall", {31'b0, bus.stall}, 32'd0);
    sbq.push_back({32'h100, 32'h11111111});
    @(posedge clk); #1;
    bus.memwrite = 1'b0;
    @(negedge clk);
    chk("single_wreq", {31'b0, bus.mem_wreq}, 32'd1);
    chk("single_waddr", bus.mem_waddr, 32'h100);
    chk("single_wdata", bus.mem_wdata, 32'h11111111);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_empty_after", {31'b0, bus.sb_empty}, 32'd1);
    chk("single_wreq_after", {31'b0, bus.mem_wreq}, 32'd0);
    @(posedge clk); #1;
    // fill to full, reject fifth store until one pop
    bus.mem_wack = 1'b0;
    for (int i = 0; i < 4; i++) store(32'(4 * i), 32'hA0 + 32'(i));
    bus.memwrite  = 1'b1;
    bus.aluout    = 32'h10;
    bus.writedata = 32'hA4;
    @(negedge clk);
    chk("full_stall", {31'b0, bus.stall}, 32'd1);
    chk("full_waddr", bus.mem_waddr, 32'h0);
    chk("full_wdata", bus.mem_wdata, 32'hA0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_reject_stall", {31'b0, bus.stall}, 32'd1);
    chk("full_hold_waddr", bus.mem_waddr, 32'h0);
    @(posedge clk); #1;
    bus.mem_wack = 1'b1;
    @(negedge clk);
    chk("full_pop_stall", {31'b0, bus.stall}, 32'd1);
    @(posedge clk); #1;
    bus.mem_wack = 1'b0;
    @(negedge clk);
    chk("after_pop_stall", {31'b0, bus.stall}, 32'd0);
    chk("after_pop_waddr", bus.mem_waddr, 32'h4);
    sbq.push_back({32'h10, 32'hA4});
    @(posedge clk); #1;
    bus.memwrite = 1'b0;
    @(negedge clk);
    chk("refull_stall", {31'b0, bus.stall}, 32'd1);
    @(posedge clk); #1;
    drain();
    // forwarding
    bus.mem_wack = 1'b0;
    store(32'h20, 32'hAAAA);
    store(32'h22, 32'hBBBB);
    bus.aluout    = 32'h20;
    bus.mem_rdata = 32'h0;
    @(negedge clk);
    chk("fwd_youngest", bus.readdata, 32'hBBBB);
    @(posedge clk); #1;
    bus.aluout = 32'h23;
    @(negedge clk);
    chk("fwd_lowbits", bus.readdata, 32'hBBBB);
    @(posedge clk); #1;
    bus.aluout    = 32'h24;
    bus.mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("fwd_miss", bus.readdata, 32'h12345678);
    chk("fwd_raddr", bus.mem_raddr, 32'h24);
    @(posedge clk); #1;
    bus.memwrite  = 1'b1;
    bus.aluout    = 32'h31;
    bus.writedata = 32'hCCCC;
    bus.mem_rdata = 32'h55555555;
    @(negedge clk);
    chk("fwd_no_same_cycle", bus.readdata, 32'h55555555);
    chk("fwd_raddr_aligned", bus.mem_raddr, 32'h30);
    sbq.push_back({32'h30, 32'hCCCC});
    @(posedge clk); #1;
    bus.memwrite = 1'b0;
    @(negedge clk);
    chk("fwd_next_cycle", bus.readdata, 32'hCCCC);
    @(posedge clk); #1;
    drain();
    // reset in the middle of a drain
    bus.mem_wack = 1'b0;
    store(32'h40, 32'h40);
    store(32'h44, 32'h44);
    store(32'h48, 32'h48);
    @(negedge clk);
    chk("mid_wreq", {31'b0, bus.mem_wreq}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_wreq", {31'b0, bus.mem_wreq}, 32'd0);
    chk("mid_rst_empty", {31'b0, bus.sb_empty}, 32'd1);
    chk("mid_rst_stall", {31'b0, bus.stall}, 32'd0);
    chk("mid_rst_waddr", bus.mem_waddr, 32'd0);
    sbq.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    bus.mem_wack = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_no_wreq", {31'b0, bus.mem_wreq}, 32'd0);
    end
    @(posedge clk); #1;
    // push and pop every cycle across pointer wrap
    for (int i = 0; i < 11; i++) begin
      bus.memwrite  = 1'b1;
      bus.aluout    = 32'h200 + 32'(4 * i);
      bus.writedata = 32'hC0DE0000 + 32'(i);
      @(negedge clk);
      chk("pp_stall", {31'b0, bus.stall}, 32'd0);
      chk("pp_wreq", {31'b0, bus.mem_wreq}, (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) chk("pp_head", bus.mem_waddr, 32'h200 + 32'(4 * (i - 1)));
      sbq.push_back({32'h200 + 32'(4 * i), 32'hC0DE0000 + 32'(i)});
      @(posedge clk); #1;
    end
    bus.memwrite = 1'b0;
    @(negedge clk);
    chk("pp_last_wreq", {31'b0, bus.mem_wreq}, 32'd1);
    chk("pp_last_waddr", bus.mem_waddr, 32'h228);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pp_final_empty", {31'b0, bus.sb_empty}, 32'd1);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
